// File: rtl/bounce_pkg.sv
// Shared types and defaults for the bouncing-box position engine.
// Contents:
//   - update FSM state encoding
//   - default screen and box geometry
//   - palette index width and speed (step) width
package bounce_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_BOX_W    = 32;
    localparam int unsigned DEF_BOX_H    = 32;
    localparam int unsigned DEF_POS_W    = 10;
    localparam int unsigned COLOR_W      = 3;
    localparam int unsigned STEP_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC_X = 2'd1,
        ST_CALC_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/bounce_axis_step.sv
// One-axis position step with edge reflection (purely combinational).
// Ports:
//   i_pos        current coordinate
//   i_dir        1 = moving toward i_max, 0 = moving toward 0
//   i_step       pixels to move this frame (0 = hold, never flips)
//   i_max        largest legal coordinate
//   o_next_pos_c clamped next coordinate
//   o_flip_c     1 when the edge was reached and direction must invert
module bounce_axis_step
    import bounce_pkg::*;
#(
    parameter int unsigned POS_W = DEF_POS_W
) (
    input  logic [POS_W-1:0]  i_pos,
    input  logic              i_dir,
    input  logic [STEP_W-1:0] i_step,
    input  logic [POS_W-1:0]  i_max,
    output logic [POS_W-1:0]  o_next_pos_c,
    output logic              o_flip_c
);

    // One extra bit so the sum toward i_max cannot wrap.
    logic [POS_W:0] w_pos_ext;
    logic [POS_W:0] w_step_ext;
    logic [POS_W:0] w_max_ext;
    logic [POS_W:0] w_sum;
    logic [POS_W:0] w_diff;

    assign w_pos_ext  = {1'b0, i_pos};
    assign w_step_ext = (POS_W+1)'(i_step);
    assign w_max_ext  = {1'b0, i_max};
    assign w_sum      = w_pos_ext + w_step_ext;
    assign w_diff     = w_pos_ext - w_step_ext;

    always_comb begin
        o_next_pos_c = i_pos;
        o_flip_c     = 1'b0;
        if (i_step != '0) begin
            if (i_dir) begin
                if (w_sum >= w_max_ext) begin
                    o_next_pos_c = i_max;
                    o_flip_c     = 1'b1;
                end else begin
                    o_next_pos_c = w_sum[POS_W-1:0];
                end
            end else begin
                if (w_pos_ext <= w_step_ext) begin
                    o_next_pos_c = '0;
                    o_flip_c     = 1'b1;
                end else begin
                    o_next_pos_c = w_diff[POS_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/bounce_motion.sv
// Per-frame position engine for the bouncing-box demo.
// On a qualified frame tick the box is stepped one axis per cycle through a
// single shared step unit, then committed atomically three edges later.
// Ports:
//   clk, rst_n      pixel clock, async active-low reset
//   i_frame_tick    one-cycle pulse at start of vertical blanking
//   i_ena           0 blocks new updates (an update in flight completes)
//   i_pause         1 ignores i_frame_tick
//   i_speed         pixels per frame per axis, latched at update start
//   i_restart       synchronous return to reset state, highest priority
//   o_box_x/o_box_y box top-left coordinate
//   o_color_idx     palette index, advances once per reflected axis
//   o_bounce_pulse  one cycle: some axis reflected this frame
//   o_corner_pulse  one cycle: both axes reflected this frame
//   o_busy          update in progress
module bounce_motion
    import bounce_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned BOX_W    = DEF_BOX_W,
    parameter int unsigned BOX_H    = DEF_BOX_H,
    parameter int unsigned POS_W    = DEF_POS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_frame_tick,
    input  logic               i_ena,
    input  logic               i_pause,
    input  logic [STEP_W-1:0]  i_speed,
    input  logic               i_restart,
    output logic [POS_W-1:0]   o_box_x,
    output logic [POS_W-1:0]   o_box_y,
    output logic [COLOR_W-1:0] o_color_idx,
    output logic               o_bounce_pulse,
    output logic               o_corner_pulse,
    output logic               o_busy
);

    localparam logic [POS_W-1:0] MAX_X = POS_W'(H_ACTIVE - BOX_W);
    localparam logic [POS_W-1:0] MAX_Y = POS_W'(V_ACTIVE - BOX_H);
    localparam logic [POS_W-1:0] RST_X = POS_W'((H_ACTIVE - BOX_W) / 2);
    localparam logic [POS_W-1:0] RST_Y = POS_W'((V_ACTIVE - BOX_H) / 2);

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic                r_dir_x;
    logic                r_dir_y;
    logic [POS_W-1:0]    r_nx;
    logic [POS_W-1:0]    r_ny;
    logic                r_flip_x;
    logic                r_flip_y;
    logic [POS_W-1:0]    r_box_x;
    logic [POS_W-1:0]    r_box_y;
    logic [COLOR_W-1:0]  r_color;
    logic                r_bounce;
    logic                r_corner;
    logic                r_busy;

    logic                w_sel_y;
    logic [POS_W-1:0]    w_pos;
    logic                w_dir;
    logic [POS_W-1:0]    w_max;
    logic [POS_W-1:0]    w_next;
    logic                w_flip;

    // Time-share the step unit: X operands in CALC_X, Y operands in CALC_Y.
    assign w_sel_y = (r_state == ST_CALC_Y);
    assign w_pos   = w_sel_y ? r_box_y : r_box_x;
    assign w_dir   = w_sel_y ? r_dir_y : r_dir_x;
    assign w_max   = w_sel_y ? MAX_Y   : MAX_X;

    bounce_axis_step #(
        .POS_W (POS_W)
    ) u_axis_step (
        .i_pos        (w_pos),
        .i_dir        (w_dir),
        .i_step       (r_step),
        .i_max        (w_max),
        .o_next_pos_c (w_next),
        .o_flip_c     (w_flip)
    );

    // Update FSM; shadow results are only made visible in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_step   <= '0;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_nx     <= '0;
            r_ny     <= '0;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
            r_box_x  <= RST_X;
            r_box_y  <= RST_Y;
            r_color  <= '0;
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
            r_busy   <= 1'b0;
        end else if (i_restart) begin
            r_state  <= ST_IDLE;
            r_step   <= '0;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_nx     <= '0;
            r_ny     <= '0;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
            r_box_x  <= RST_X;
            r_box_y  <= RST_Y;
            r_color  <= '0;
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_tick && i_ena && !i_pause) begin
                        r_step  <= i_speed;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC_X;
                    end
                end
                ST_CALC_X: begin
                    r_nx     <= w_next;
                    r_flip_x <= w_flip;
                    r_state  <= ST_CALC_Y;
                end
                ST_CALC_Y: begin
                    r_ny     <= w_next;
                    r_flip_y <= w_flip;
                    r_state  <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_box_x  <= r_nx;
                    r_box_y  <= r_ny;
                    r_dir_x  <= r_dir_x ^ r_flip_x;
                    r_dir_y  <= r_dir_y ^ r_flip_y;
                    r_color  <= r_color + COLOR_W'(r_flip_x) + COLOR_W'(r_flip_y);
                    r_bounce <= r_flip_x | r_flip_y;
                    r_corner <= r_flip_x & r_flip_y;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_box_x        = r_box_x;
    assign o_box_y        = r_box_y;
    assign o_color_idx    = r_color;
    assign o_bounce_pulse = r_bounce;
    assign o_corner_pulse = r_corner;
    assign o_busy         = r_busy;

endmodule
